alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational ALU. The block keeps the eight legacy operations (encodings 0–7 unchanged), adds signed compare and shifts, and adds iterative multiply and divide. All results and flags are registered behind a valid/ready interface. It sits between the decode/issue stage and writeback of the NPC datapath; the issue stage holds a request until `in_ready` is high.

---
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative multiply and divide.
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SW  = $clog2(WIDTH);
    localparam int CW  = SW + 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [1:0]           iter_op;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [SW-1:0]        shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     iter_res;

    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        shamt   = b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) & (add_w[MSB] != a[MSB]);
            end
            4'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) & (sub_w[MSB] != a[MSB]);
            end
            4'd2:  alu_res = ~a;
            4'd3:  alu_res = a & b;
            4'd4:  alu_res = a | b;
            4'd5:  alu_res = a ^ b;
            4'd6:  alu_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
            4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            4'd8:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:  alu_res = a << shamt;
            4'd10: alu_res = a >> shamt;
            4'd11: alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // acc holds {high product | remainder, low product | quotient} for both iterative ops.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (iter_op[1]) begin
            if (div_diff[WIDTH])
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
        iter_res = iter_op[0] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            iter_op   <= '0;
            b_q       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        iter_op  <= op[1:0];
                        b_q      <= b;
                        acc      <= {{WIDTH{1'b0}}, a};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (op[3:2] == 2'b11) begin
                            state <= CALC;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result    <= iter_res;
                        zero      <= (iter_res == '0);
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 instance for legacy ops and a WIDTH=32 instance
// for shifts, compares, multiply/divide, backpressure and reset.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [3:0]  n_op;
    logic [3:0]  n_a, n_b, n_result;
    logic        n_zero, n_carry, n_overflow;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [3:0]  w_op;
    logic [31:0] w_a, w_b, w_result;
    logic        w_zero, w_carry, w_overflow;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op), .a(n_a), .b(n_b),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result),
        .zero(n_zero), .carry(n_carry), .overflow(n_overflow)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .a(w_a), .b(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
        .zero(w_zero), .carry(w_carry), .overflow(w_overflow)
    );

    // Issues one request and waits (bounded) until out_valid; lat is the cycle index it appeared in.
    task automatic run4(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                        output int lat);
        n_op = o; n_a = x; n_b = y; n_in_valid = 1'b1; n_out_ready = 1'b0;
        @(posedge clk); #1;
        n_in_valid = 1'b0; n_a = 4'hF; n_b = 4'h0;
        lat = 1;
        while (n_out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release4;
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
    endtask

    task automatic run32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic ready_low);
        w_op = o; w_a = x; w_b = y; w_in_valid = 1'b1; w_out_ready = 1'b0;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_a = 32'h5A5A5A5A; w_b = 32'h0; w_op = 4'd2;
        lat = 1;
        ready_low = 1'b1;
        while (w_out_valid !== 1'b1 && lat < 100) begin
            if (w_in_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (w_in_ready !== 1'b0) ready_low = 1'b0;
    endtask

    task automatic release32;
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (w_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready got %b want 1", w_in_ready); end
        checks++; if (w_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid got %b want 0", w_out_valid); end
        checks++; if (w_result !== 32'h0 || w_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset result/zero got %h/%b want 0/0", w_result, w_zero); end
        checks++; if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset4 ready/valid got %b/%b want 1/0", n_in_ready, n_out_valid); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_legacy4;
        int lat;
        run4(4'd0, 4'd9, 4'd8, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL add4 latency got %0d want 1", lat); end
        checks++; if ({n_result, n_carry, n_overflow} !== {4'd1, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL add4 got r=%0d c=%b v=%b want r=1 c=1 v=1", n_result, n_carry, n_overflow); end
        release4;
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add4 release in_ready got %b want 1", n_in_ready); end
        run4(4'd1, 4'd3, 4'd5, lat);
        checks++; if ({n_result, n_carry, n_overflow} !== {4'd14, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL sub4 got r=%0d c=%b v=%b want r=14 c=1 v=0", n_result, n_carry, n_overflow); end
        release4;
        run4(4'd7, 4'd7, 4'd7, lat);
        checks++; if ({n_result, n_zero} !== {4'd1, 1'b0}) begin errors++; $display("[TB] FAIL eq4 got r=%0d z=%b want r=1 z=0", n_result, n_zero); end
        release4;
        run4(4'd3, 4'd5, 4'd10, lat);
        checks++; if ({n_result, n_zero} !== {4'd0, 1'b1}) begin errors++; $display("[TB] FAIL and4 got r=%0d z=%b want r=0 z=1", n_result, n_zero); end
        release4;
        run4(4'd5, 4'd12, 4'd10, lat);
        checks++; if ({n_result, n_carry} !== {4'd6, 1'b0}) begin errors++; $display("[TB] FAIL xor4 got r=%0d c=%b want r=6 c=0", n_result, n_carry); end
        release4;
    endtask

    task automatic test_shift_cmp32;
        int lat;
        logic rl;
        run32(4'd11, 32'h80000000, 32'd4, lat, rl);
        checks++; if (w_result !== 32'hF8000000) begin errors++; $display("[TB] FAIL sra got %h want f8000000", w_result); end
        release32;
        run32(4'd10, 32'h80000000, 32'd4, lat, rl);
        checks++; if (w_result !== 32'h08000000) begin errors++; $display("[TB] FAIL srl got %h want 08000000", w_result); end
        release32;
        run32(4'd8, 32'hFFFFFFFF, 32'd1, lat, rl);
        checks++; if (w_result !== 32'd1) begin errors++; $display("[TB] FAIL slt got %h want 1", w_result); end
        release32;
        run32(4'd6, 32'hFFFFFFFF, 32'd1, lat, rl);
        checks++; if ({w_result, w_zero} !== {32'd0, 1'b1}) begin errors++; $display("[TB] FAIL sltu got %h z=%b want 0 z=1", w_result, w_zero); end
        release32;
        run32(4'd9, 32'h00000003, 32'd33, lat, rl);
        checks++; if (w_result !== 32'h00000006) begin errors++; $display("[TB] FAIL sll33 got %h want 6", w_result); end
        release32;
        run32(4'd0, 32'h7FFFFFFF, 32'd1, lat, rl);
        checks++; if ({w_result, w_carry, w_overflow} !== {32'h80000000, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL add32 got %h c=%b v=%b want 80000000 c=0 v=1", w_result, w_carry, w_overflow); end
        release32;
        run32(4'd1, 32'h80000000, 32'd1, lat, rl);
        checks++; if ({w_result, w_carry, w_overflow} !== {32'h7FFFFFFF, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL sub32 got %h c=%b v=%b want 7fffffff c=0 v=1", w_result, w_carry, w_overflow); end
        release32;
    endtask

    task automatic test_muldiv;
        int lat;
        logic rl;
        run32(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rl);
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mul latency got %0d want 33", lat); end
        checks++; if (rl !== 1'b1) begin errors++; $display("[TB] FAIL mul in_ready low got %b want 1", rl); end
        checks++; if ({w_result, w_carry} !== {32'h00000001, 1'b0}) begin errors++; $display("[TB] FAIL mul got %h c=%b want 00000001 c=0", w_result, w_carry); end
        release32;
        run32(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rl);
        checks++; if (w_result !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu got %h want fffffffe", w_result); end
        release32;
        run32(4'd12, 32'd1234, 32'd5678, lat, rl);
        checks++; if (w_result !== 32'd7006652) begin errors++; $display("[TB] FAIL mul small got %0d want 7006652", w_result); end
        release32;
        run32(4'd14, 32'd100, 32'd7, lat, rl);
        checks++; if (w_result !== 32'd14 || lat !== 33) begin errors++; $display("[TB] FAIL divu got %0d lat %0d want 14 lat 33", w_result, lat); end
        release32;
        run32(4'd15, 32'd100, 32'd7, lat, rl);
        checks++; if (w_result !== 32'd2 || lat !== 33) begin errors++; $display("[TB] FAIL remu got %0d lat %0d want 2 lat 33", w_result, lat); end
        release32;
        run32(4'd14, 32'd5, 32'd0, lat, rl);
        checks++; if (w_result !== 32'hFFFFFFFF || lat !== 33) begin errors++; $display("[TB] FAIL divu0 got %h lat %0d want ffffffff lat 33", w_result, lat); end
        release32;
        run32(4'd15, 32'd123, 32'd0, lat, rl);
        checks++; if (w_result !== 32'd123 || lat !== 33) begin errors++; $display("[TB] FAIL remu0 got %0d lat %0d want 123 lat 33", w_result, lat); end
        release32;
        run32(4'd15, 32'd21, 32'd7, lat, rl);
        checks++; if ({w_result, w_zero} !== {32'd0, 1'b1}) begin errors++; $display("[TB] FAIL remu zero got %0d z=%b want 0 z=1", w_result, w_zero); end
        release32;
    endtask

    task automatic test_back_to_back;
        n_out_ready = 1'b1;
        n_op = 4'd0; n_a = 4'd1; n_b = 4'd1; n_in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if ({n_out_valid, n_in_ready, n_result} !== {1'b1, 1'b0, 4'd2}) begin errors++; $display("[TB] FAIL b2b first got v=%b r=%b res=%0d want v=1 r=0 res=2", n_out_valid, n_in_ready, n_result); end
        n_a = 4'd2; n_b = 4'd3;
        @(posedge clk); #1;
        checks++; if ({n_out_valid, n_in_ready} !== {1'b0, 1'b1}) begin errors++; $display("[TB] FAIL b2b idle got v=%b r=%b want v=0 r=1", n_out_valid, n_in_ready); end
        @(posedge clk); #1;
        checks++; if ({n_out_valid, n_result} !== {1'b1, 4'd5}) begin errors++; $display("[TB] FAIL b2b second got v=%b res=%0d want v=1 res=5", n_out_valid, n_result); end
        n_in_valid = 1'b0;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat;
        logic rl;
        int bad;
        run32(4'd1, 32'd3, 32'd5, lat, rl);
        w_in_valid = 1'b1; w_op = 4'd0; w_a = 32'd1; w_b = 32'd1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({w_out_valid, w_in_ready, w_result, w_carry, w_overflow, w_zero} !==
                {1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0}) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL backpressure hold got %0d bad cycles want 0", bad); end
        checks++; if ({w_out_valid, w_result} !== {1'b1, 32'hFFFFFFFE}) begin errors++; $display("[TB] FAIL backpressure end got v=%b %h want v=1 fffffffe", w_out_valid, w_result); end
        w_in_valid = 1'b0;
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        checks++; if ({w_in_ready, w_out_valid} !== {1'b1, 1'b0}) begin errors++; $display("[TB] FAIL backpressure release got r=%b v=%b want r=1 v=0", w_in_ready, w_out_valid); end
    endtask

    task automatic test_reset_midop;
        int lat;
        logic rl;
        w_op = 4'd14; w_a = 32'd1000; w_b = 32'd3; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({w_out_valid, w_in_ready, w_result, w_zero} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL midop reset got v=%b r=%b res=%h z=%b want v=0 r=1 res=0 z=0", w_out_valid, w_in_ready, w_result, w_zero); end
        rst_n = 1'b1;
        run32(4'd0, 32'd2, 32'd2, lat, rl);
        checks++; if (lat !== 1 || w_result !== 32'd4) begin errors++; $display("[TB] FAIL post-reset add got %0d lat %0d want 4 lat 1", w_result, lat); end
        release32;
    endtask

    initial begin
        rst_n = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_op = '0; n_a = '0; n_b = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = '0; w_a = '0; w_b = '0;
        test_reset;
        test_legacy4;
        test_shift_cmp32;
        test_muldiv;
        test_back_to_back;
        test_backpressure;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
